instr_fetch_unit: RTL

Instruction fetch and program-counter block that feeds the MIPS-style control unit. It holds the PC, fetches the word at the PC from instruction memory over a req/ack handshake, and presents it with a valid/ready handshake to the decode stage. When decode retires the instruction, it applies the `pc_control` code produced by the control unit to compute the next PC: sequential, j/jal, jr, or taken branch.

---
 rtl/instr_fetch_unit.sv | 94 +++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// PC register plus a fetch/present FSM: IDLE -> REQ (held until imem_ack) -> VALID (held until instr_ready).
// Throughput is one instruction per 2 cycles at zero wait; decode stalls hold VALID, and a misaligned jr parks in HALT.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  pc_control,
  input  logic [25:0] jump_target,
  input  logic [31:0] jr_target,
  input  logic [15:0] branch_offset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misaligned_fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] next_pc;
  logic        jr_misaligned;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // Reserved codes (1xx) fall through to sequential.
  always_comb begin
    next_pc       = pc_plus4;
    jr_misaligned = (pc_control == 3'b010) && (jr_target[1:0] != 2'b00);
    case (pc_control)
      3'b001:  next_pc = {pc_plus4[31:28], jump_target, 2'b00};
      3'b010:  next_pc = jr_target;
      3'b011:  next_pc = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
      default: next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      pc               <= RESET_PC;
      instruction      <= 32'h0;
      instr_valid      <= 1'b0;
      imem_req         <= 1'b0;
      misaligned_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            instruction <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= VALID;
          end
        end
        VALID: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (jr_misaligned) begin
              // PC stays at the offending instruction for post-mortem.
              misaligned_fault <= 1'b1;
              state            <= HALT;
            end else begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              state    <= REQ;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
